// File: rtl/frame_header_inserter.sv
// Purpose: prepends a HEADER_BYTES header to a payload beat stream and realigns the payload behind it.
// Latency: the first output beat is registered in the cycle after the header handshake.
// Backpressure: the output register holds while m_tvalid && !m_tready; s_tready follows m_tready combinationally.
module frame_header_inserter #(
  parameter int DATA_WIDTH   = 64,
  parameter int HEADER_BYTES = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [8*HEADER_BYTES-1:0] hdr_data,
  input  logic                      hdr_valid,
  output logic                      hdr_ready,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
  input  logic                      s_tlast,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  output logic [DATA_WIDTH-1:0]     m_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_tkeep,
  output logic                      m_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      frame_done
);

  localparam int B   = DATA_WIDTH / 8;
  localparam int H   = HEADER_BYTES;
  localparam int R   = H % B;
  localparam int F   = H / B;
  localparam int HPW = (F + 1) * DATA_WIDTH;           // header padded to whole beats
  localparam int CW  = (F > 0) ? $clog2(F + 1) : 1;
  localparam int NW  = $clog2(B + 1);
  localparam int RSH = (R == 0) ? 0 : 8 * (B - R);     // bit offset of the bytes that spill into carry

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, FLUSH} state_t;

  state_t                state;
  logic [8*H-1:0]        hdr_reg;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] carry;
  logic [NW-1:0]         flush_n;

  logic                  adv;
  logic [HPW-1:0]        hdr_src;
  logic [CW-1:0]         hdr_idx;
  logic [DATA_WIDTH-1:0] hdr_beat;
  logic [DATA_WIDTH-1:0] hdr_carry;
  logic [DATA_WIDTH-1:0] merged;
  logic [NW-1:0]         n_in;

  function automatic logic [B-1:0] low_ones(input int nbytes);
    logic [B-1:0] m;
    for (int i = 0; i < B; i++) m[i] = (i < nbytes);
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] bytes_mask(input logic [B-1:0] k);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < B; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  assign adv       = !m_tvalid || m_tready;
  assign hdr_ready = (state == IDLE);
  assign s_tready  = (state == PAYLOAD) && adv;

  // In IDLE the header is taken straight from the port so beat 0 leaves without a bubble
  assign hdr_src   = (state == IDLE) ? {{(HPW - 8*H){1'b0}}, hdr_data}
                                     : {{(HPW - 8*H){1'b0}}, hdr_reg};
  assign hdr_idx   = (state == IDLE) ? '0 : cnt;
  assign hdr_beat  = hdr_src[hdr_idx*DATA_WIDTH +: DATA_WIDTH];
  assign hdr_carry = hdr_src[F*DATA_WIDTH +: DATA_WIDTH];

  // Carry bytes occupy lanes 0..R-1, the incoming beat shifts up behind them
  assign merged    = (carry & bytes_mask(low_ones(R))) | (s_tdata << (8*R));

  // Count valid bytes of the incoming beat (keep is low-contiguous)
  always_comb begin
    n_in = '0;
    for (int i = 0; i < B; i++) n_in = n_in + NW'(s_tkeep[i]);
  end

  // Frame sequencing and the registered output beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hdr_reg    <= '0;
      cnt        <= '0;
      carry      <= '0;
      flush_n    <= '0;
      m_tdata    <= '0;
      m_tkeep    <= '0;
      m_tlast    <= 1'b0;
      m_tvalid   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= m_tvalid && m_tready && m_tlast;
      if (adv) begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (hdr_valid) begin
            hdr_reg <= hdr_data;
            cnt     <= '0;
            if (F == 0) begin
              carry <= hdr_carry;
              state <= PAYLOAD;
            end else if (adv) begin
              m_tdata  <= hdr_beat;
              m_tkeep  <= '1;
              m_tvalid <= 1'b1;
              if (F == 1) begin
                carry <= hdr_carry;
                state <= PAYLOAD;
              end else begin
                cnt   <= CW'(1);
                state <= HDR;
              end
            end else begin
              state <= HDR;
            end
          end
        end
        HDR: begin
          if (adv) begin
            m_tdata  <= hdr_beat;
            m_tkeep  <= '1;
            m_tvalid <= 1'b1;
            cnt      <= cnt + CW'(1);
            if (cnt == CW'(F - 1)) begin
              carry <= hdr_carry;
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (adv && s_tvalid) begin
            m_tvalid <= 1'b1;
            if (R == 0) begin
              m_tdata <= s_tdata;
              m_tkeep <= s_tkeep;
              m_tlast <= s_tlast;
              if (s_tlast) state <= IDLE;
            end else if (!s_tlast) begin
              m_tdata <= merged;
              m_tkeep <= '1;
              carry   <= s_tdata >> RSH;
            end else if (int'(n_in) <= B - R) begin
              m_tdata <= merged & bytes_mask(low_ones(R + int'(n_in)));
              m_tkeep <= low_ones(R + int'(n_in));
              m_tlast <= 1'b1;
              state   <= IDLE;
            end else begin
              m_tdata <= merged;
              m_tkeep <= '1;
              carry   <= s_tdata >> RSH;
              flush_n <= NW'(int'(n_in) - (B - R));
              state   <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (adv) begin
            m_tdata  <= carry & bytes_mask(low_ones(int'(flush_n)));
            m_tkeep  <= low_ones(int'(flush_n));
            m_tlast  <= 1'b1;
            m_tvalid <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
